// File: rtl/game_tick_scheduler.sv
// Game timebase: turns selected divided-clock rising edges into single-cycle tick enables,
// one per clock, arbitrated by fixed priority (channel 0 highest) with a per-channel queue.
module game_tick_scheduler #(
    parameter int NUM_CH = 3,
    parameter int SEL_W  = 5
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [31:0]             dividedClocks,
    input  logic                    start,
    input  logic                    pause,
    input  logic [NUM_CH*SEL_W-1:0] rate_sel,
    output logic [NUM_CH-1:0]       tick,
    output logic [NUM_CH-1:0]       pending,
    output logic [NUM_CH-1:0]       overrun,
    output logic [1:0]              state
);

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        RUN    = 2'b01,
        PAUSED = 2'b10
    } state_t;

    state_t              state_q, state_d;
    logic [NUM_CH-1:0]   sel_bit_p0;
    logic [NUM_CH-1:0]   prev_bit_p1;
    logic [NUM_CH-1:0]   evt;
    logic [NUM_CH-1:0]   grant;
    logic                found;

    assign state = state_q;

    // ---- stage p0: pick each channel's divided-clock bit and detect rising edges
    always_comb begin
        sel_bit_p0 = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            sel_bit_p0[i] = dividedClocks[rate_sel[i*SEL_W +: SEL_W]];
        end
    end

    assign evt = sel_bit_p0 & ~prev_bit_p1 & {NUM_CH{state_q == RUN}};

    // Lowest-index pending channel wins; nothing is granted outside RUN.
    always_comb begin
        grant = '0;
        found = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (pending[i] && !found) begin
                grant[i] = 1'b1;
                found    = 1'b1;
            end
        end
        if (state_q != RUN) begin
            grant = '0;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (pause) state_d = PAUSED;
            PAUSED:  if (start) state_d = RUN;
            default: state_d = IDLE;
        endcase
    end

    // ---- stage p1: queue, tick and sticky overrun registers
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            prev_bit_p1 <= '0;
            tick        <= '0;
            pending     <= '0;
            overrun     <= '0;
        end else begin
            // Edge history keeps tracking while paused so resuming never fabricates an edge.
            prev_bit_p1 <= sel_bit_p0;
            state_q     <= state_d;
            case (state_q)
                RUN: begin
                    tick    <= grant;
                    pending <= (pending & ~grant) | evt;
                    overrun <= overrun | (evt & pending & ~grant);
                end
                PAUSED: begin
                    tick <= '0;
                end
                default: begin
                    tick    <= '0;
                    pending <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_game_tick_scheduler.sv
// Directed table-driven bench for game_tick_scheduler plus multi-cycle corner sequences.
module tb_game_tick_scheduler;

    logic        clock;
    logic        reset;
    logic [31:0] dividedClocks;
    logic        start;
    logic        pause;
    logic [14:0] rate_sel;
    logic [2:0]  tick;
    logic [2:0]  pending;
    logic [2:0]  overrun;
    logic [1:0]  state;

    int errors = 0;
    int checks = 0;

    localparam logic [14:0] RS0 = {5'd2, 5'd1, 5'd0};
    localparam logic [14:0] RS4 = {5'd2, 5'd1, 5'd4};

    game_tick_scheduler #(.NUM_CH(3), .SEL_W(5)) dut (
        .clock         (clock),
        .reset         (reset),
        .dividedClocks (dividedClocks),
        .start         (start),
        .pause         (pause),
        .rate_sel      (rate_sel),
        .tick          (tick),
        .pending       (pending),
        .overrun       (overrun),
        .state         (state)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct packed {
        logic       rst;
        logic       st;
        logic       pa;
        logic [2:0] dc;
        logic [1:0] es;
        logic [2:0] et;
        logic [2:0] ep;
        logic [2:0] eo;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic r, s, p, input logic [2:0] d,
                                input logic [1:0] es, input logic [2:0] et, ep, eo);
        vec_t v;
        v.rst = r; v.st = s; v.pa = p; v.dc = d;
        v.es = es; v.et = et; v.ep = ep; v.eo = eo;
        return v;
    endfunction

    task automatic step(input logic r, s, p, input logic [31:0] d, input logic [14:0] rs);
        reset = r; start = s; pause = p; dividedClocks = d; rate_sel = rs;
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    initial begin
        int tick_cnt;
        reset = 1'b1; start = 1'b0; pause = 1'b0; dividedClocks = '0; rate_sel = RS0;

        // rows: rst st pa dc | state tick pending overrun (outputs after the clock edge)
        tbl.push_back(mk(1,0,0,3'b000, 2'b00,3'b000,3'b000,3'b000));
        tbl.push_back(mk(0,1,0,3'b000, 2'b01,3'b000,3'b000,3'b000));
        tbl.push_back(mk(0,0,0,3'b001, 2'b01,3'b000,3'b001,3'b000));
        tbl.push_back(mk(0,0,0,3'b001, 2'b01,3'b001,3'b000,3'b000));
        tbl.push_back(mk(0,0,0,3'b000, 2'b01,3'b000,3'b000,3'b000));
        tbl.push_back(mk(0,0,0,3'b001, 2'b01,3'b000,3'b001,3'b000));
        tbl.push_back(mk(0,0,0,3'b001, 2'b01,3'b001,3'b000,3'b000));
        tbl.push_back(mk(0,0,0,3'b000, 2'b01,3'b000,3'b000,3'b000));
        tbl.push_back(mk(0,0,0,3'b111, 2'b01,3'b000,3'b111,3'b000));
        tbl.push_back(mk(0,0,0,3'b111, 2'b01,3'b001,3'b110,3'b000));
        tbl.push_back(mk(0,0,0,3'b111, 2'b01,3'b010,3'b100,3'b000));
        tbl.push_back(mk(0,0,0,3'b000, 2'b01,3'b100,3'b000,3'b000));
        tbl.push_back(mk(0,0,0,3'b000, 2'b01,3'b000,3'b000,3'b000));
        // ch2 re-arms on the very cycle it is granted: stays pending, no overrun
        tbl.push_back(mk(0,0,0,3'b110, 2'b01,3'b000,3'b110,3'b000));
        tbl.push_back(mk(0,0,0,3'b000, 2'b01,3'b010,3'b100,3'b000));
        tbl.push_back(mk(0,0,0,3'b100, 2'b01,3'b100,3'b100,3'b000));
        tbl.push_back(mk(0,0,0,3'b000, 2'b01,3'b100,3'b000,3'b000));
        tbl.push_back(mk(0,0,0,3'b000, 2'b01,3'b000,3'b000,3'b000));
        // pause mid-queue with 110 captured, edges ignored, resume drains 010 then 100
        tbl.push_back(mk(0,0,1,3'b110, 2'b10,3'b000,3'b110,3'b000));
        tbl.push_back(mk(0,0,1,3'b000, 2'b10,3'b000,3'b110,3'b000));
        tbl.push_back(mk(0,0,0,3'b110, 2'b10,3'b000,3'b110,3'b000));
        tbl.push_back(mk(0,0,0,3'b000, 2'b10,3'b000,3'b110,3'b000));
        tbl.push_back(mk(0,0,0,3'b110, 2'b10,3'b000,3'b110,3'b000));
        tbl.push_back(mk(0,1,1,3'b110, 2'b01,3'b000,3'b110,3'b000));
        tbl.push_back(mk(0,0,0,3'b110, 2'b01,3'b010,3'b100,3'b000));
        tbl.push_back(mk(0,0,0,3'b110, 2'b01,3'b100,3'b000,3'b000));
        tbl.push_back(mk(0,0,0,3'b000, 2'b01,3'b000,3'b000,3'b000));
        // bit rises while paused and stays high across resume: no tick
        tbl.push_back(mk(0,0,1,3'b000, 2'b10,3'b000,3'b000,3'b000));
        tbl.push_back(mk(0,0,0,3'b001, 2'b10,3'b000,3'b000,3'b000));
        tbl.push_back(mk(0,1,0,3'b001, 2'b01,3'b000,3'b000,3'b000));
        tbl.push_back(mk(0,0,0,3'b001, 2'b01,3'b000,3'b000,3'b000));
        tbl.push_back(mk(0,0,0,3'b001, 2'b01,3'b000,3'b000,3'b000));
        // IDLE ignores pause and edges; start+pause: IDLE->RUN, RUN->PAUSED, PAUSED->RUN
        tbl.push_back(mk(1,0,0,3'b000, 2'b00,3'b000,3'b000,3'b000));
        tbl.push_back(mk(0,0,1,3'b000, 2'b00,3'b000,3'b000,3'b000));
        tbl.push_back(mk(0,0,0,3'b001, 2'b00,3'b000,3'b000,3'b000));
        tbl.push_back(mk(0,1,1,3'b001, 2'b01,3'b000,3'b000,3'b000));
        tbl.push_back(mk(0,1,1,3'b001, 2'b10,3'b000,3'b000,3'b000));
        tbl.push_back(mk(0,1,1,3'b000, 2'b01,3'b000,3'b000,3'b000));
        tbl.push_back(mk(0,0,0,3'b000, 2'b01,3'b000,3'b000,3'b000));

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].rst, tbl[i].st, tbl[i].pa, {29'd0, tbl[i].dc}, RS0);
            chk($sformatf("row%0d_state", i), {6'd0, state},   {6'd0, tbl[i].es});
            chk($sformatf("row%0d_tick", i),  {5'd0, tick},    {5'd0, tbl[i].et});
            chk($sformatf("row%0d_pend", i),  {5'd0, pending}, {5'd0, tbl[i].ep});
            chk($sformatf("row%0d_ovr", i),   {5'd0, overrun}, {5'd0, tbl[i].eo});
        end

        // Overrun: ch2 re-fires while ch0/ch1 keep it queued
        step(1, 0, 0, 32'd0, RS0);
        step(0, 1, 0, 32'd0, RS0);
        step(0, 0, 0, 32'd7, RS0);
        chk("ovr_pend0", {5'd0, pending}, 8'h07);
        step(0, 0, 0, 32'd3, RS0);
        chk("ovr_tick1", {5'd0, tick}, 8'h01);
        chk("ovr_pend1", {5'd0, pending}, 8'h06);
        step(0, 0, 0, 32'd4, RS0);
        chk("ovr_tick2", {5'd0, tick}, 8'h02);
        chk("ovr_pend2", {5'd0, pending}, 8'h04);
        chk("ovr_set", {5'd0, overrun}, 8'h04);
        step(0, 0, 0, 32'd0, RS0);
        chk("ovr_tick3", {5'd0, tick}, 8'h04);
        for (int k = 0; k < 20; k++) begin
            step(0, 0, 0, {29'd0, 3'($urandom_range(0, 7))}, RS0);
            chk($sformatf("ovr_onehot%0d", k), {7'd0, $onehot0(tick)}, 8'h01);
            chk($sformatf("ovr_sticky%0d", k), {7'd0, overrun[2]}, 8'h01);
        end
        for (int k = 0; k < 4; k++) step(0, 0, 0, 32'd0, RS0);
        chk("drain_pend", {5'd0, pending}, 8'h00);

        // Reset mid-RUN with pending=011
        step(0, 0, 0, 32'd3, RS0);
        chk("rst_pre_pend", {5'd0, pending}, 8'h03);
        step(1, 0, 0, 32'd0, RS0);
        chk("rst_state", {6'd0, state},   8'h00);
        chk("rst_tick",  {5'd0, tick},    8'h00);
        chk("rst_pend",  {5'd0, pending}, 8'h00);
        chk("rst_ovr",   {5'd0, overrun}, 8'h00);

        // rate_sel switch onto an already-high bit yields exactly one event
        step(0, 1, 0, 32'h10, RS0);
        step(0, 0, 0, 32'h10, RS0);
        chk("sw_pend_before", {5'd0, pending}, 8'h00);
        step(0, 0, 0, 32'h10, RS4);
        chk("sw_pend_after", {5'd0, pending}, 8'h01);
        tick_cnt = 0;
        for (int k = 0; k < 6; k++) begin
            step(0, 0, 0, 32'h10, RS4);
            if (tick[0]) tick_cnt++;
        end
        chk("sw_tick_count", 8'(tick_cnt), 8'h01);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
